// File: rtl/regfile_wb_arbiter_pkg.sv
// Types and constants shared by the writeback arbiter and its holding slots.
`include "config.inc.v"

package regfile_wb_arbiter_pkg;
  localparam int DATA_W_DEF = `DMEM_DATA_WIDTH;
  localparam int REG_AW_DEF = `REG_IDX_WIDTH;
  localparam int ID_EXEC    = `WB_REQ_EXEC;
  localparam int ID_LOAD    = `WB_REQ_LOAD;

  typedef enum logic {
    REQ_EXEC = 1'(`WB_REQ_EXEC),
    REQ_LOAD = 1'(`WB_REQ_LOAD)
  } wb_req_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic wb_req_e other_req(input wb_req_e r);
    return (r == REQ_EXEC) ? REQ_LOAD : REQ_EXEC;
  endfunction
endpackage

// File: rtl/config.inc.v
// Shared constants for the register file and its writeback path.
`ifndef CONFIG_INC_V
`define CONFIG_INC_V
`define DMEM_DATA_WIDTH 8
`define REGS_COUNT 16
`define REG_IDX_WIDTH 4
`define WB_REQ_EXEC 0
`define WB_REQ_LOAD 1
`endif

// File: rtl/regfile_wb_slot.sv
// One-entry writeback holding register; can drain and refill on the same edge.
module regfile_wb_slot
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  output logic              ready,
  input  logic [REG_AW-1:0] in_idx,
  input  logic [DATA_W-1:0] in_value,
  input  logic              drain,
  output logic              full,
  output logic [REG_AW-1:0] out_idx,
  output logic [DATA_W-1:0] out_value
);
  slot_state_e       state_reg, state_next;
  logic [REG_AW-1:0] idx_reg;
  logic [DATA_W-1:0] value_reg;
  logic              load;

  assign full      = (state_reg == SLOT_FULL);
  assign ready     = !rst && (!full || drain);
  assign load      = valid && ready;
  assign out_idx   = idx_reg;
  assign out_value = value_reg;

  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = SLOT_FULL;
    end else if (drain) begin
      state_next = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SLOT_EMPTY;
      idx_reg   <= '0;
      value_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        idx_reg   <= in_idx;
        value_reg <= in_value;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter (EXEC vs LOAD) for the register-file write port.
// Optional REGFILE_WB_BYPASS_EN adds forwarding outputs for decode reads.
`include "config.inc.v"

module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exec_valid,
  output logic              exec_ready,
  input  logic [REG_AW-1:0] exec_reg,
  input  logic [DATA_W-1:0] exec_value,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [REG_AW-1:0] load_reg,
  input  logic [DATA_W-1:0] load_value,
  output logic              reg_d_enable,
  output logic [REG_AW-1:0] reg_d,
  output logic [DATA_W-1:0] reg_d_value,
  input  logic [REG_AW-1:0] rd_a,
  input  logic [REG_AW-1:0] rd_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic              fwd_a_valid,
  output logic [DATA_W-1:0] fwd_a_value,
  output logic              fwd_b_valid,
  output logic [DATA_W-1:0] fwd_b_value
`endif
);
  genvar gi;

  logic [1:0]        slot_valid, slot_ready, slot_full, slot_drain, accept, full_next;
  logic [REG_AW-1:0] in_idx   [2];
  logic [DATA_W-1:0] in_value [2];
  logic [REG_AW-1:0] held_idx [2];
  logic [DATA_W-1:0] held_value [2];

  wb_req_e rr_reg, rr_next;
  wb_req_e older_reg, older_next;
  wb_req_e grant_id;
  logic    grant_valid;

  assign slot_valid[ID_EXEC] = exec_valid;
  assign slot_valid[ID_LOAD] = load_valid;
  assign in_idx[ID_EXEC]     = exec_reg;
  assign in_idx[ID_LOAD]     = load_reg;
  assign in_value[ID_EXEC]   = exec_value;
  assign in_value[ID_LOAD]   = load_value;
  assign exec_ready          = slot_ready[ID_EXEC];
  assign load_ready          = slot_ready[ID_LOAD];
  assign accept              = slot_valid & slot_ready;

  for (gi = 0; gi < 2; gi++) begin : g_slot
    regfile_wb_slot #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .valid     (slot_valid[gi]),
      .ready     (slot_ready[gi]),
      .in_idx    (in_idx[gi]),
      .in_value  (in_value[gi]),
      .drain     (slot_drain[gi]),
      .full      (slot_full[gi]),
      .out_idx   (held_idx[gi]),
      .out_value (held_value[gi])
    );
  end

  // Same-register pairs go oldest-first so the later write lands last.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ_EXEC;
    rr_next     = rr_reg;
    slot_drain  = 2'b00;
    if (&slot_full) begin
      grant_valid = 1'b1;
      if (held_idx[ID_EXEC] == held_idx[ID_LOAD]) begin
        grant_id = older_reg;
      end else begin
        grant_id = rr_reg;
        rr_next  = other_req(rr_reg);
      end
    end else if (slot_full[ID_EXEC]) begin
      grant_valid = 1'b1;
      grant_id    = REQ_EXEC;
    end else if (slot_full[ID_LOAD]) begin
      grant_valid = 1'b1;
      grant_id    = REQ_LOAD;
    end
    if (grant_valid) begin
      slot_drain[grant_id] = 1'b1;
    end
  end

  always_comb begin
    older_next = older_reg;
    full_next  = (slot_full & ~slot_drain) | accept;
    if (&full_next) begin
      if (&accept) begin
        older_next = REQ_EXEC;
      end else if (accept[ID_EXEC]) begin
        older_next = REQ_LOAD;
      end else if (accept[ID_LOAD]) begin
        older_next = REQ_EXEC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_reg       <= REQ_EXEC;
      older_reg    <= REQ_EXEC;
      reg_d_enable <= 1'b0;
      reg_d        <= '0;
      reg_d_value  <= '0;
    end else begin
      rr_reg       <= rr_next;
      older_reg    <= older_next;
      reg_d_enable <= grant_valid && (held_idx[grant_id] != '0);
      if (grant_valid) begin
        reg_d       <= held_idx[grant_id];
        reg_d_value <= held_value[grant_id];
      end
    end
  end

  logic [REG_AW-1:0] rd_idx [2];
  logic [1:0]        busy_arr;
  assign rd_idx[0] = rd_a;
  assign rd_idx[1] = rd_b;

`ifdef REGFILE_WB_BYPASS_EN
  logic [1:0]        fwd_valid_arr;
  logic [DATA_W-1:0] fwd_value_arr [2];
  assign fwd_a_valid = fwd_valid_arr[0];
  assign fwd_b_valid = fwd_valid_arr[1];
  assign fwd_a_value = fwd_value_arr[0];
  assign fwd_b_value = fwd_value_arr[1];
`endif

  for (gi = 0; gi < 2; gi++) begin : g_hazard
    logic nz, hit_ex, hit_ld, hit_out;
    assign nz      = (rd_idx[gi] != '0);
    assign hit_ex  = nz && slot_full[ID_EXEC] && (held_idx[ID_EXEC] == rd_idx[gi]);
    assign hit_ld  = nz && slot_full[ID_LOAD] && (held_idx[ID_LOAD] == rd_idx[gi]);
    assign hit_out = nz && reg_d_enable && (reg_d == rd_idx[gi]);
`ifdef REGFILE_WB_BYPASS_EN
    // When EXEC is the older slot, LOAD holds the youngest value.
    logic ld_first;
    assign ld_first = (older_reg == REQ_EXEC);
    assign fwd_valid_arr[gi] = hit_ex || hit_ld || hit_out;
    assign fwd_value_arr[gi] = (ld_first && hit_ld) ? held_value[ID_LOAD] :
                               hit_ex                ? held_value[ID_EXEC] :
                               hit_ld                ? held_value[ID_LOAD] :
                                                       reg_d_value;
    assign busy_arr[gi] = (hit_ex || hit_ld || hit_out) && !fwd_valid_arr[gi];
`else
    assign busy_arr[gi] = hit_ex || hit_ld || hit_out;
`endif
  end

  assign busy_a = busy_arr[0];
  assign busy_b = busy_arr[1];
  assign stall  = |busy_arr;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed + randomized bench for regfile_wb_arbiter against a timestamp-based reference model.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int AW = REG_AW_DEF;

  logic          clk;
  logic          rst;
  logic          exec_valid, exec_ready, load_valid, load_ready;
  logic [AW-1:0] exec_reg, load_reg, reg_d, rd_a, rd_b;
  logic [DW-1:0] exec_value, load_value, reg_d_value;
  logic          reg_d_enable, busy_a, busy_b, stall;
`ifdef REGFILE_WB_BYPASS_EN
  logic          fwd_a_valid, fwd_b_valid;
  logic [DW-1:0] fwd_a_value, fwd_b_value;
`endif

  regfile_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .exec_valid   (exec_valid),
    .exec_ready   (exec_ready),
    .exec_reg     (exec_reg),
    .exec_value   (exec_value),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_reg     (load_reg),
    .load_value   (load_value),
    .reg_d_enable (reg_d_enable),
    .reg_d        (reg_d),
    .reg_d_value  (reg_d_value),
    .rd_a         (rd_a),
    .rd_b         (rd_b),
    .busy_a       (busy_a),
    .busy_b       (busy_b),
    .stall        (stall)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .fwd_a_valid  (fwd_a_valid),
    .fwd_a_value  (fwd_a_value),
    .fwd_b_valid  (fwd_b_valid),
    .fwd_b_value  (fwd_b_value)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: slots carry an acceptance stamp; smaller stamp = older.
  int m_full[2], m_idx[2], m_val[2], m_stamp[2];
  int m_rr, m_oen, m_oreg, m_oval, m_cyc;
  bit rec_en;
  int strobe_reg[$];
  int strobe_val[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int m_grant();
    if (m_full[0] != 0 && m_full[1] != 0) begin
      if (m_idx[0] == m_idx[1]) return (m_stamp[0] < m_stamp[1]) ? 0 : 1;
      return m_rr;
    end
    if (m_full[0] != 0) return 0;
    if (m_full[1] != 0) return 1;
    return -1;
  endfunction

  function automatic int m_ready(input int i);
    if (rst) return 0;
    return (m_full[i] == 0 || m_grant() == i) ? 1 : 0;
  endfunction

  function automatic int m_busy_raw(input int rd);
    if (rd == 0) return 0;
    for (int i = 0; i < 2; i++)
      if (m_full[i] != 0 && m_idx[i] == rd) return 1;
    if (m_oen != 0 && m_oreg == rd) return 1;
    return 0;
  endfunction

  function automatic void m_fwd(input int rd, output int v, output int val);
    int order[2];
    v = 0;
    val = 0;
    if (rd == 0) return;
    order[0] = (m_stamp[1] > m_stamp[0]) ? 1 : 0;
    order[1] = 1 - order[0];
    for (int k = 0; k < 2; k++) begin
      if (m_full[order[k]] != 0 && m_idx[order[k]] == rd) begin
        v = 1;
        val = m_val[order[k]];
        return;
      end
    end
    if (m_oen != 0 && m_oreg == rd) begin
      v = 1;
      val = m_oval;
    end
  endfunction

  function automatic int m_busy(input int rd);
`ifdef REGFILE_WB_BYPASS_EN
    int v, val;
    m_fwd(rd, v, val);
    return (m_busy_raw(rd) != 0 && v == 0) ? 1 : 0;
`else
    return m_busy_raw(rd);
`endif
  endfunction

  task automatic model_edge();
    int g, rdy[2];
    rdy[0] = m_ready(0);
    rdy[1] = m_ready(1);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_full[i] = 0; m_idx[i] = 0; m_val[i] = 0; m_stamp[i] = 0;
      end
      m_rr = 0; m_oen = 0; m_oreg = 0; m_oval = 0;
    end else begin
      g = m_grant();
      if (g >= 0) begin
        m_oen  = (m_idx[g] != 0) ? 1 : 0;
        m_oreg = m_idx[g];
        m_oval = m_val[g];
        if (m_full[0] != 0 && m_full[1] != 0 && m_idx[0] != m_idx[1]) m_rr = 1 - g;
        m_full[g] = 0;
      end else begin
        m_oen = 0;
      end
      if (exec_valid && rdy[0] != 0) begin
        m_full[0] = 1; m_idx[0] = int'(exec_reg); m_val[0] = int'(exec_value); m_stamp[0] = m_cyc * 2;
      end
      if (load_valid && rdy[1] != 0) begin
        m_full[1] = 1; m_idx[1] = int'(load_reg); m_val[1] = int'(load_value); m_stamp[1] = m_cyc * 2 + 1;
      end
    end
    m_cyc++;
  endtask

  task automatic check_all();
    check("exec_ready", exec_ready, m_ready(0));
    check("load_ready", load_ready, m_ready(1));
    check("reg_d_enable", reg_d_enable, m_oen);
    check("reg_d", reg_d, m_oreg);
    check("reg_d_value", reg_d_value, m_oval);
    check("busy_a", busy_a, m_busy(int'(rd_a)));
    check("busy_b", busy_b, m_busy(int'(rd_b)));
    check("stall", stall, (m_busy(int'(rd_a)) | m_busy(int'(rd_b))));
`ifdef REGFILE_WB_BYPASS_EN
    begin
      int va, xa, vb, xb;
      m_fwd(int'(rd_a), va, xa);
      m_fwd(int'(rd_b), vb, xb);
      check("fwd_a_valid", fwd_a_valid, va);
      check("fwd_b_valid", fwd_b_valid, vb);
      if (va != 0) check("fwd_a_value", fwd_a_value, xa);
      if (vb != 0) check("fwd_b_value", fwd_b_value, xb);
    end
`endif
  endtask

  // One clock: model follows the edge, new inputs go in at negedge, outputs checked 1 time unit later.
  task automatic step(input logic r, input logic ev, input logic [AW-1:0] er, input logic [DW-1:0] evl,
                      input logic lv, input logic [AW-1:0] lr, input logic [DW-1:0] lvl,
                      input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = r; exec_valid = ev; exec_reg = er; exec_value = evl;
    load_valid = lv; load_reg = lr; load_value = lvl; rd_a = ra; rd_b = rb;
    #1;
    check_all();
    if (rec_en && reg_d_enable === 1'b1) begin
      strobe_reg.push_back(int'(reg_d));
      strobe_val.push_back(int'(reg_d_value));
    end
  endtask

  task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ra, rb);
  endtask

  int ex_list[3] = '{1, 2, 3};
  int ld_list[3] = '{4, 5, 6};
  int exp_rr[6]  = '{1, 4, 2, 5, 3, 6};

  initial begin
    int ie, il;
    bit ev, lv;
    rst = 1'b1; exec_valid = 1'b0; load_valid = 1'b0;
    exec_reg = '0; load_reg = '0; exec_value = '0; load_value = '0; rd_a = '0; rd_b = '0;
    m_cyc = 0; rec_en = 1'b0;

    // Reset state
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    check("rst_exec_ready", exec_ready, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_reg_d_enable", reg_d_enable, 0);
    check("rst_reg_d", reg_d, 0);

    // Single EXEC write: r3 <= 0x5A
    step(1'b0, 1'b1, 4'd3, 8'h5A, 1'b0, '0, '0, 4'd3, '0);
    check("t1_ready", exec_ready, 1);
    idle(4'd3, '0);
    check("t1_busy_c2", busy_a, 1);
    check("t1_en_c2", reg_d_enable, 0);
    idle(4'd3, '0);
    check("t1_en_c3", reg_d_enable, 1);
    check("t1_reg_c3", reg_d, 3);
    check("t1_val_c3", reg_d_value, 8'h5A);
    check("t1_busy_c3", busy_a, 1);
    idle(4'd3, '0);
    check("t1_en_c4", reg_d_enable, 0);
    check("t1_busy_c4", busy_a, 0);

    // r0 discard
    step(1'b0, 1'b0, '0, '0, 1'b1, 4'd0, 8'hFF, 4'd0, '0);
    for (int k = 0; k < 3; k++) begin
      idle(4'd0, '0);
      check("r0_en", reg_d_enable, 0);
      check("r0_ready", load_ready, 1);
      check("r0_busy", busy_a, 0);
    end

    // Reset mid-operation with both slots full
    step(1'b0, 1'b1, 4'd1, 8'hA1, 1'b1, 4'd2, 8'hB2, 4'd1, 4'd2);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 4'd1, 4'd2);
    check("mid_rst_exec_ready", exec_ready, 0);
    check("mid_rst_load_ready", load_ready, 0);
    idle(4'd1, 4'd2);
    check("post_rst_en", reg_d_enable, 0);
    check("post_rst_ready", exec_ready & load_ready, 1);
    check("post_rst_busy", busy_a | busy_b, 0);
    idle(4'd1, 4'd2);
    check("post_rst_en2", reg_d_enable, 0);

    // Round-robin with distinct registers
    rec_en = 1'b1;
    ie = 0; il = 0;
    for (int k = 0; k < 12; k++) begin
      ev = (ie < 3);
      lv = (il < 3);
      step(1'b0, ev, AW'(ev ? ex_list[ie] : 0), 8'h10 + 8'(ie), lv, AW'(lv ? ld_list[il] : 0),
           8'h20 + 8'(il), '0, '0);
      if (ev && m_ready(0) != 0) ie++;
      if (lv && m_ready(1) != 0) il++;
    end
    check("rr_count", strobe_reg.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < strobe_reg.size()) check($sformatf("rr_order%0d", k), strobe_reg[k], exp_rr[k]);

    // Same-register ordering
    strobe_reg.delete();
    strobe_val.delete();
    step(1'b0, 1'b1, 4'd7, 8'h11, 1'b0, '0, '0, 4'd7, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 4'd7, 8'h22, 4'd7, '0);
    for (int k = 0; k < 5; k++) idle(4'd7, '0);
    check("same_count", strobe_val.size(), 2);
    if (strobe_val.size() == 2) begin
      check("same_first", strobe_val[0], 8'h11);
      check("same_second", strobe_val[1], 8'h22);
    end
    rec_en = 1'b0;

`ifdef REGFILE_WB_BYPASS_EN
    // Forwarding from a pending EXEC slot
    step(1'b0, 1'b1, 4'd9, 8'h33, 1'b0, '0, '0, '0, 4'd9);
    idle('0, 4'd9);
    check("byp_valid", fwd_b_valid, 1);
    check("byp_value", fwd_b_value, 8'h33);
    check("byp_busy", busy_b, 0);
    check("byp_stall", stall, 0);
`endif

    // Randomized traffic with frequent register collisions
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), DW'($urandom),
           $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), DW'($urandom),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
    for (int k = 0; k < 4; k++) idle(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
